addsub_arbiter: RTL and testbench
=================================

# addsub_arbiter

Two-requester arbiter and result register for a shared WIDTH-bit add/subtract unit. Each requester presents operands and an op bit. The block grants one request per cycle using round-robin arbitration, computes the two's-complement sum or difference, and holds the result in a single output register under a valid/ready handshake. It sits between the instruction sequencers and the ALU result bus, and keeps a running count of completed operations.

## Interface
- WIDTH, 8, operand and result width in bits (at least 2)
- CNT_WIDTH, 16, width of the completed-operation counter

- clk  in  1  system clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-high reset
- req0 / req1  in  1  request from requester 0 / 1; held high with operands stable until granted
- op0 / op1  in  1  0 = add, 1 = subtract (A - B)
- a0, b0 / a1, b1  in  WIDTH  operands for requester 0 / 1
- gnt0 / gnt1  out  1  combinational accept strobe; the request is consumed on the clock edge where gnt is high
- res_valid  out  1  output register holds an unconsumed result
- res_ready  in  1  consumer accepts the result on an edge where res_valid and res_ready are both high
- res_id  out  1  index of the requester that produced the result
- res_s  out  WIDTH  sum or difference
- res_carry  out  1  carry-out of the MSB; for subtract, 1 means no borrow
- res_overflow  out  1  signed overflow
- op_count  out  CNT_WIDTH  number of results consumed, modulo 2^CNT_WIDTH

## Operation
- Arithmetic, computed at WIDTH+1 bits:
  - x = B XOR {WIDTH{op}}; full = A + x + op.
  - S = full[WIDTH-1:0]; carry = full[WIDTH].
  - overflow = carry XOR (carry into bit WIDTH-1).
- Slot state machine, SLOT ∈ {EMPTY, FULL}:
  - EMPTY: a grant → FULL.
  - FULL with res_ready: a grant → stays FULL (new result loads); no grant → EMPTY.
  - FULL without res_ready: stays FULL, and no grant is issued.
- can_accept = (SLOT==EMPTY) | res_ready.
- Round-robin pointer `last`, 1 bit, reset value 1. This gives requester 0 priority on the first contention after reset.
- Arbitration, with both requests evaluated only when can_accept is high:
  - One request pending → it wins.
  - Both pending → the winner is the requester that is not `last`.
  - `last` updates to the winner on every grant.
  - With no grant, `last` holds.
- gnt0 and gnt1 are never high together. Both are low whenever reset is high or can_accept is low.
- On a grant edge, the output register loads S, carry, overflow and res_id from the winner's inputs.
- op_count increments by 1 on every edge where res_valid & res_ready, and wraps from all-ones to 0.
- Reset mid-operation:
  - All registers return to reset values immediately.
  - Any held result is discarded and not counted.
  - A requester whose gnt was not observed on a clock edge must keep requesting.

## Timing
- Reset values:
  - res_valid=0, res_id=0, res_s=0, res_carry=0, res_overflow=0, op_count=0.
  - last=1; gnt0=gnt1=0 while reset is asserted.
- Latency: a grant at edge N gives res_valid=1 with the result after edge N.
- Throughput: one operation per cycle while res_ready stays high.
- Back-to-back: res_valid stays high across consecutive grants and res_s changes every cycle.
- Backpressure: with res_valid=1 and res_ready=0, no grant is issued and outputs hold stable indefinitely.
- Simultaneous consume and grant: the old result counts and the new one loads on the same edge; res_valid does not drop.
- gnt depends combinationally on req*, res_ready, SLOT and `last`. It has no combinational path from the operands.
- Requesters must not drop req before their grant. If they do, the behaviour is defined but the op is simply never performed.

## Test plan
- Arithmetic corners (WIDTH=8), each via req0 with res_ready=1; each result must appear one cycle later with res_id=0:
  - 7F+01 → S=80, carry=0, ovf=1
  - FF+01 → S=00, carry=1, ovf=0
  - 05−07 → S=FE, carry=0, ovf=0
  - 80−01 → S=7F, carry=1, ovf=1
  - 00−00 → S=00, carry=1, ovf=0
- Contention after reset: req0 and req1 held together with res_ready=1.
  - Grants must alternate 0,1,0,1 on consecutive cycles.
  - res_id must follow the same sequence one cycle later.
  - op_count must reach 4 after four consumes.
- Backpressure:
  - With res_valid=1, hold res_ready=0 for 5 cycles while both req are high: no gnt, res_s stable.
  - Raise res_ready: the grant goes out in the same cycle, with no res_valid gap.
- Single requester streaming: req1 only for 3 cycles with res_ready=1 → gnt1 every cycle, and a result every cycle from the second cycle on.
- Reset mid-stream:
  - Assert reset asynchronously between edges while res_valid=1 → res_valid=0, op_count=0 and gnts=0 immediately.
  - After release, the first contention grants requester 0.
- Counter wrap (CNT_WIDTH=4): complete 17 operations → op_count=1.

Source files
------------

// File: rtl/addsub_arbiter.sv
// Two-requester round-robin arbiter feeding a shared add/subtract unit.
// The single result register sits behind a valid/ready handshake and counts consumed results.
module addsub_arbiter #(
    parameter int unsigned WIDTH     = 8,
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 req0,
    input  logic                 req1,
    input  logic                 op0,
    input  logic                 op1,
    input  logic [WIDTH-1:0]     a0,
    input  logic [WIDTH-1:0]     b0,
    input  logic [WIDTH-1:0]     a1,
    input  logic [WIDTH-1:0]     b1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic                 res_id,
    output logic [WIDTH-1:0]     res_s,
    output logic                 res_carry,
    output logic                 res_overflow,
    output logic [CNT_WIDTH-1:0] op_count
);

    localparam logic [0:0] SlotEmpty = 1'b0;
    localparam logic [0:0] SlotFull  = 1'b1;

    logic [0:0]           slot_q, slot_d;
    logic                 last_q, last_d;
    logic                 id_q;
    logic [WIDTH-1:0]     s_q;
    logic                 carry_q;
    logic                 ovf_q;
    logic [CNT_WIDTH-1:0] cnt_q;

    logic                 can_accept;
    logic                 grant;
    logic                 sel_op;
    logic [WIDTH-1:0]     sel_a;
    logic [WIDTH-1:0]     sel_b;
    logic [WIDTH-1:0]     x;
    logic [WIDTH:0]       full;
    logic [WIDTH-1:0]     low;
    logic                 carry_msb;
    logic                 ovf;

    assign can_accept = (slot_q == SlotEmpty) | res_ready;

    // last_q names the previous winner, so the other requester wins a tie.
    always_comb begin
        gnt0 = ~reset & can_accept & req0 & (~req1 | last_q);
        gnt1 = ~reset & can_accept & req1 & (~req0 | ~last_q);
    end

    assign grant = gnt0 | gnt1;

    always_comb begin
        sel_op = gnt1 ? op1 : op0;
        sel_a  = gnt1 ? a1 : a0;
        sel_b  = gnt1 ? b1 : b0;
    end

    // Subtract is A + ~B + 1; the low WIDTH-1 bits give the carry into the MSB.
    always_comb begin
        x         = sel_b ^ {WIDTH{sel_op}};
        full      = {1'b0, sel_a} + {1'b0, x} + {{WIDTH{1'b0}}, sel_op};
        low       = {1'b0, sel_a[WIDTH-2:0]} + {1'b0, x[WIDTH-2:0]}
                    + {{(WIDTH-1){1'b0}}, sel_op};
        carry_msb = low[WIDTH-1];
        ovf       = full[WIDTH] ^ carry_msb;
    end

    always_comb begin
        slot_d = slot_q;
        case (slot_q)
            SlotEmpty: if (grant) slot_d = SlotFull;
            SlotFull:  if (res_ready && !grant) slot_d = SlotEmpty;
            default:   slot_d = SlotEmpty;
        endcase
        last_d = grant ? gnt1 : last_q;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            slot_q  <= SlotEmpty;
            last_q  <= 1'b1;
            id_q    <= 1'b0;
            s_q     <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            slot_q <= slot_d;
            last_q <= last_d;
            if (grant) begin
                id_q    <= gnt1;
                s_q     <= full[WIDTH-1:0];
                carry_q <= full[WIDTH];
                ovf_q   <= ovf;
            end
            if ((slot_q == SlotFull) && res_ready) begin
                cnt_q <= cnt_q + CNT_WIDTH'(1);
            end
        end
    end

    always_comb begin
        res_valid    = (slot_q == SlotFull);
        res_id       = id_q;
        res_s        = s_q;
        res_carry    = carry_q;
        res_overflow = ovf_q;
        op_count     = cnt_q;
    end

endmodule

// File: tb/tb_addsub_arbiter.sv
// Bench for addsub_arbiter: directed corner cases plus random traffic,
// all checked against an arithmetic reference model on every falling edge.
module tb_addsub_arbiter;

    localparam int unsigned W  = 8;
    localparam int unsigned CW = 4;

    logic          clk;
    logic          reset;
    logic          req0, req1, op0, op1;
    logic [W-1:0]  a0, b0, a1, b1;
    logic          gnt0, gnt1;
    logic          res_valid, res_ready, res_id, res_carry, res_overflow;
    logic [W-1:0]  res_s;
    logic [CW-1:0] op_count;

    int tests;
    int fails;
    logic check_en;

    addsub_arbiter #(.WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .reset(reset),
        .req0(req0), .req1(req1), .op0(op0), .op1(op1),
        .a0(a0), .b0(b0), .a1(a1), .b1(b1),
        .gnt0(gnt0), .gnt1(gnt1),
        .res_valid(res_valid), .res_ready(res_ready), .res_id(res_id),
        .res_s(res_s), .res_carry(res_carry), .res_overflow(res_overflow),
        .op_count(op_count)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic from integer values: {ovf, carry, s}.
    function automatic logic [W+1:0] calc(input logic [W-1:0] a, input logic [W-1:0] b,
                                          input logic op);
        int u, sa, sb, sv;
        logic [W-1:0] s;
        logic c, v;
        sa = $signed(a);
        sb = $signed(b);
        if (op) begin
            u  = int'(a) - int'(b);
            c  = (a >= b);
            sv = sa - sb;
        end else begin
            u  = int'(a) + int'(b);
            c  = (u >= (1 << W));
            sv = sa + sb;
        end
        s = u[W-1:0];
        v = (sv > (1 << (W - 1)) - 1) || (sv < -(1 << (W - 1)));
        return {v, c, s};
    endfunction

    logic          m_valid, m_last, m_id, m_c, m_v;
    logic [W-1:0]  m_s;
    logic [CW-1:0] m_cnt;

    function automatic logic exp_gnt(input logic which);
        logic can;
        can = !m_valid || res_ready;
        if (reset || !can) return 1'b0;
        if (which == 1'b0) return req0 && (!req1 || m_last);
        return req1 && (!req0 || !m_last);
    endfunction

    always @(posedge clk or posedge reset) begin
        logic g0, g1;
        logic [W+1:0] r;
        if (reset) begin
            m_valid <= 1'b0; m_last <= 1'b1; m_id <= 1'b0;
            m_s <= '0; m_c <= 1'b0; m_v <= 1'b0; m_cnt <= '0;
        end else begin
            g0 = exp_gnt(1'b0);
            g1 = exp_gnt(1'b1);
            if (m_valid && res_ready) m_cnt <= m_cnt + 1'b1;
            if (g0 || g1) begin
                r = g1 ? calc(a1, b1, op1) : calc(a0, b0, op0);
                m_valid <= 1'b1;
                m_id    <= g1;
                m_s     <= r[W-1:0];
                m_c     <= r[W];
                m_v     <= r[W+1];
                m_last  <= g1;
            end else if (res_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            check("gnt0", gnt0, exp_gnt(1'b0));
            check("gnt1", gnt1, exp_gnt(1'b1));
            check("res_valid", res_valid, m_valid);
            check("res_id", res_id, m_id);
            check("res_s", res_s, m_s);
            check("res_carry", res_carry, m_c);
            check("res_overflow", res_overflow, m_v);
            check("op_count", op_count, m_cnt);
        end
    end

    task automatic corner(input logic [W-1:0] a, input logic [W-1:0] b, input logic op,
                          input logic [W-1:0] es, input logic ec, input logic ev);
        req0 = 1'b1; a0 = a; b0 = b; op0 = op; req1 = 1'b0; res_ready = 1'b1;
        @(negedge clk);
        check("corner_gnt0", gnt0, 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        check("corner_valid", res_valid, 1);
        check("corner_id", res_id, 0);
        check("corner_s", res_s, es);
        check("corner_carry", res_carry, ec);
        check("corner_ovf", res_overflow, ev);
    endtask

    task automatic pulse_reset();
        #2 reset = 1'b1;
        @(posedge clk); #2 reset = 1'b0;
    endtask

    logic g0s, g1s;

    initial begin
        tests = 0; fails = 0; check_en = 1'b0;
        reset = 1'b1; res_ready = 1'b0;
        req0 = 1'b0; req1 = 1'b0; op0 = 1'b0; op1 = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        #12 reset = 1'b0;
        check("reset_valid", res_valid, 0);
        check("reset_count", op_count, 0);
        check("reset_s", res_s, 0);
        check_en = 1'b1;

        // Contention right after reset alternates starting with requester 0.
        @(posedge clk); #1;
        req0 = 1'b1; req1 = 1'b1; res_ready = 1'b1;
        a0 = 8'h10; b0 = 8'h01; a1 = 8'h20; b1 = 8'h02; op0 = 1'b0; op1 = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rr_gnt0", gnt0, (i % 2 == 0));
            check("rr_gnt1", gnt1, (i % 2 == 1));
            @(posedge clk); #1;
            check("rr_id", res_id, (i % 2 == 1));
        end
        req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        check("rr_count4", op_count, 4);

        corner(8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1);
        corner(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0);
        corner(8'h05, 8'h07, 1'b1, 8'hFE, 1'b0, 1'b0);
        corner(8'h80, 8'h01, 1'b1, 8'h7F, 1'b1, 1'b1);
        corner(8'h00, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0);
        corner(8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0);

        // Backpressure: held result, no grants, then grant in the same cycle as ready.
        res_ready = 1'b0; req0 = 1'b1; req1 = 1'b1;
        a1 = 8'h03; b1 = 8'h04; op1 = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_nognt", {gnt0, gnt1}, 0);
            check("bp_hold_s", res_s, 8'h46);
            check("bp_hold_valid", res_valid, 1);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        #1;
        check("bp_release_gnt1", gnt1, 1);
        check("bp_release_gnt0", gnt0, 0);
        @(posedge clk); #1;
        req1 = 1'b0;
        check("bp_no_gap", res_valid, 1);
        check("bp_id", res_id, 1);
        check("bp_s", res_s, 8'h07);
        @(negedge clk);
        check("bp_then_gnt0", gnt0, 1);
        @(posedge clk); #1;
        req0 = 1'b0;

        // Single requester streaming.
        req1 = 1'b1;
        for (int i = 0; i < 3; i++) begin
            a1 = W'($urandom); b1 = W'($urandom); op1 = 1'($urandom);
            @(negedge clk);
            check("stream_gnt1", gnt1, 1);
            @(posedge clk); #1;
            check("stream_valid", res_valid, 1);
            check("stream_id", res_id, 1);
        end

        // Asynchronous reset between edges with a result held.
        req0 = 1'b1;
        #2 reset = 1'b1;
        #1;
        check("arst_valid", res_valid, 0);
        check("arst_count", op_count, 0);
        check("arst_gnts", {gnt0, gnt1}, 0);
        @(posedge clk); #2 reset = 1'b0;
        @(negedge clk);
        check("post_rst_gnt0", gnt0, 1);
        @(posedge clk); #1;
        req0 = 1'b0;
        @(negedge clk);
        check("post_rst_gnt1", gnt1, 1);
        @(posedge clk); #1;
        req1 = 1'b0;

        // 17 operations from reset wrap a 4-bit counter to 1.
        pulse_reset();
        req0 = 1'b1; res_ready = 1'b1;
        for (int i = 0; i < 17; i++) begin
            a0 = W'($urandom); b0 = W'($urandom); op0 = 1'($urandom);
            @(negedge clk);
            @(posedge clk); #1;
        end
        req0 = 1'b0;
        @(posedge clk); #1;
        check("wrap_count", op_count, 1);

        // Random traffic; requesters hold until granted.
        for (int cyc = 0; cyc < 800; cyc++) begin
            @(negedge clk);
            g0s = gnt0; g1s = gnt1;
            @(posedge clk); #1;
            if (!req0 || g0s) begin
                req0 = 1'($urandom); a0 = W'($urandom); b0 = W'($urandom); op0 = 1'($urandom);
            end
            if (!req1 || g1s) begin
                req1 = 1'($urandom); a1 = W'($urandom); b1 = W'($urandom); op1 = 1'($urandom);
            end
            res_ready = ($urandom_range(0, 3) != 0);
        end

        @(negedge clk);
        check_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
